// File: rtl/fft_frame_sequencer_if.sv
// Core-side port bundle of the FFT frame sequencer: sample stream into the
// pipelined FFT core and the core's output-bin indication coming back.
interface fft_frame_sequencer_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned NALL  = 9
);
    logic             core_en;
    logic [WIDTH-1:0] core_din;
    logic [NALL-1:0]  core_cnt;
    logic             fft_en;
    logic [NALL-1:0]  fft_cnt;

    modport master (
        output core_en, core_din, core_cnt,
        input  fft_en, fft_cnt
    );

    modport slave (
        input  core_en, core_din, core_cnt,
        output fft_en, fft_cnt
    );
endinterface

// File: rtl/fft_frame_sequencer.sv
// Sample-strobe divider, frame packer and in-flight tracker in front of the FFT core.
// Optional DRAIN watchdog is compiled in when FFT_SEQ_WDOG_EN is defined.
module fft_frame_sequencer #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned NALL   = 9,
    parameter logic [23:0] FDIV   = 24'd400000,
    parameter int unsigned FCNT_W = 16
) (
    input  logic                     clk,
    input  logic                     areset,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     cont,
    input  logic                     clr_err,
    input  logic signed [WIDTH-1:0]  adc_data,
    output logic                     samp_tick,
    fft_frame_sequencer_if.master    core,
    output logic                     busy,
    output logic                     frame_done,
    output logic [FCNT_W-1:0]        frames_out,
    output logic                     overrun,
    output logic                     timeout
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    state_t                    state, state_nxt;
    logic [23:0]               div_cnt;
    logic [NALL-1:0]           idx;
    logic                      cont_r;
    logic                      stop_pend;
    logic [1:0]                inflight;
    logic                      core_en_r;
    logic signed [WIDTH-1:0]   core_din_r;
    logic [NALL-1:0]           core_cnt_r;

    logic                      tick;
    logic                      start_acq;
    logic                      frame_end;
    logic                      fft_hit;
    logic                      ovr_set;
    logic                      wd_fire;

    assign tick      = (state == CAPTURE) && (div_cnt == FDIV - 24'd1);
    assign frame_end = core_en_r && (core_cnt_r == '1);
    assign fft_hit   = core.fft_en && (core.fft_cnt == '1);
    assign ovr_set   = frame_end && !fft_hit && (inflight >= 2'd2);

    assign samp_tick     = tick;
    assign busy          = (state != IDLE);
    assign core.core_en  = core_en_r;
    assign core.core_din = core_din_r;
    assign core.core_cnt = core_cnt_r;

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start_acq = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = CAPTURE;
                    start_acq = 1'b1;
                end
            end
            CAPTURE: begin
                // A stop arriving in the frame-end cycle itself still ends the run.
                if (frame_end && !(cont_r && !stop_pend && !stop))
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                if (inflight == 2'd0 || wd_fire)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            div_cnt    <= '0;
            idx        <= '0;
            cont_r     <= 1'b0;
            stop_pend  <= 1'b0;
            core_en_r  <= 1'b0;
            core_din_r <= '0;
            core_cnt_r <= '0;
        end else begin
            if (start_acq) begin
                div_cnt   <= '0;
                idx       <= '0;
                cont_r    <= cont;
                stop_pend <= 1'b0;
            end else if (state == CAPTURE) begin
                if (state_nxt == DRAIN || tick) div_cnt <= '0;
                else                            div_cnt <= div_cnt + 24'd1;
                if (stop) stop_pend <= 1'b1;
            end

            core_en_r <= tick;
            if (tick) begin
                core_din_r <= adc_data;
                core_cnt_r <= idx;
                idx        <= idx + NALL'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            inflight   <= '0;
            overrun    <= 1'b0;
            frame_done <= 1'b0;
            frames_out <= '0;
        end else begin
            // Coincident frame entry and exit cancel; entry at 2 saturates.
            if (wd_fire)
                inflight <= '0;
            else if (frame_end && !fft_hit) begin
                if (inflight < 2'd2) inflight <= inflight + 2'd1;
            end else if (fft_hit && !frame_end && inflight != 2'd0)
                inflight <= inflight - 2'd1;

            if (ovr_set)      overrun <= 1'b1;
            else if (clr_err) overrun <= 1'b0;

            frame_done <= fft_hit;
            if (fft_hit) frames_out <= frames_out + FCNT_W'(1);
        end
    end

`ifdef FFT_SEQ_WDOG_EN
    logic [NALL+2:0] wd_cnt;
    logic            timeout_r;

    assign wd_fire = (state == DRAIN) && (inflight != 2'd0) && (wd_cnt == '1) && !core.fft_en;
    assign timeout = timeout_r;

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            wd_cnt    <= '0;
            timeout_r <= 1'b0;
        end else begin
            if (state != DRAIN || core.fft_en) wd_cnt <= '0;
            else                               wd_cnt <= wd_cnt + (NALL+3)'(1);

            if (wd_fire)      timeout_r <= 1'b1;
            else if (clr_err) timeout_r <= 1'b0;
        end
    end
`else
    assign wd_fire = 1'b0;
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Randomized bench for fft_frame_sequencer (NALL=3, FDIV=4) against a
// sample-schedule reference model; per-cycle output comparison.
module tb_fft_frame_sequencer;

    localparam int WIDTH  = 16;
    localparam int NALL   = 3;
    localparam int FCNT_W = 16;
    localparam int FDIV   = 4;
    localparam int FRAME  = 1 << NALL;
    localparam int FLEN   = FDIV * FRAME;

    logic                    clk     = 1'b0;
    logic                    areset  = 1'b0;
    logic                    start   = 1'b0;
    logic                    stop    = 1'b0;
    logic                    cont    = 1'b0;
    logic                    clr_err = 1'b0;
    logic signed [WIDTH-1:0] adc_data = '0;
    logic                    samp_tick, busy, frame_done, overrun, timeout;
    logic [FCNT_W-1:0]       frames_out;

    fft_frame_sequencer_if #(.WIDTH(WIDTH), .NALL(NALL)) core_if ();

    fft_frame_sequencer #(
        .WIDTH (WIDTH),
        .NALL  (NALL),
        .FDIV  (24'(FDIV)),
        .FCNT_W(FCNT_W)
    ) dut (
        .clk       (clk),
        .areset    (areset),
        .start     (start),
        .stop      (stop),
        .cont      (cont),
        .clr_err   (clr_err),
        .adc_data  (adc_data),
        .samp_tick (samp_tick),
        .core      (core_if),
        .busy      (busy),
        .frame_done(frame_done),
        .frames_out(frames_out),
        .overrun   (overrun),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Reference model: an acquisition is described by its first busy cycle and sample count
    int s_cyc      = -1;
    int n_samp     = 0;
    int drain_exit = -1;
    int plan_n     = 0;
    int m_infl     = 0;
    int m_frames   = 0;
    bit m_ovr      = 1'b0;
    bit m_tmo      = 1'b0;
    bit m_fd       = 1'b0;
    bit auto_ret   = 1'b0;
    int next_free  = 0;
`ifdef FFT_SEQ_WDOG_EN
    int m_wd       = 0;
`endif
    int               fft_plan[int];
    logic [WIDTH-1:0] adc_hist[int];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    function automatic bit ce_at(input int n, output int k);
        k = 0;
        if (s_cyc < 0 || n <= s_cyc || ((n - s_cyc) % FDIV) != 0) return 1'b0;
        k = (n - s_cyc) / FDIV - 1;
        return k < n_samp;
    endfunction

    function automatic bit tick_at(input int n);
        if (s_cyc < 0 || n < s_cyc || ((n - s_cyc) % FDIV) != FDIV - 1) return 1'b0;
        return ((n - s_cyc) / FDIV) < n_samp;
    endfunction

    function automatic bit busy_at(input int n);
        return s_cyc >= 0 && n >= s_cyc && (drain_exit < 0 || n <= drain_exit);
    endfunction

    function automatic bit in_drain(input int n);
        return busy_at(n) && n >= s_cyc + FDIV * n_samp + 1;
    endfunction

    // Frames captured when stop is driven 'offs' cycles after the first busy cycle
    function automatic int frames_for_stop(input int offs);
        return (offs + FLEN - 1) / FLEN;
    endfunction

    task automatic compare();
        int k;
        bit ce;
        ce = ce_at(cyc, k);
        check("samp_tick", 32'(samp_tick), 32'(tick_at(cyc)));
        check("core_en", 32'(core_if.core_en), 32'(ce));
        if (ce) begin
            check("core_cnt", 32'(core_if.core_cnt), 32'(k % FRAME));
            check("core_din", 32'(core_if.core_din), 32'(adc_hist[s_cyc + FDIV * (k + 1) - 1]));
        end
        check("busy", 32'(busy), 32'(busy_at(cyc)));
        check("frame_done", 32'(frame_done), 32'(m_fd));
        check("frames_out", 32'(frames_out), 32'(m_frames % (1 << FCNT_W)));
        check("overrun", 32'(overrun), 32'(m_ovr));
        check("timeout", 32'(timeout), 32'(m_tmo));
    endtask

    task automatic step();
        int  n;
        int  k;
        int  b0;
        bit  inc, hit, fe, fire, oset;
        n = cyc;
        adc_data = WIDTH'($urandom);
        adc_hist[n] = adc_data;
        fe = fft_plan.exists(n);
        if (fe) begin
            core_if.fft_en  = 1'b1;
            core_if.fft_cnt = NALL'(fft_plan[n]);
        end else begin
            core_if.fft_en  = 1'b0;
            core_if.fft_cnt = NALL'($urandom);
        end
        hit  = fe && fft_plan[n] == FRAME - 1;
        inc  = ce_at(n, k) && (k % FRAME == FRAME - 1);
        fire = 1'b0;
        oset = 1'b0;

        if (inc && auto_ret) begin
            b0 = ((next_free > n + 1) ? next_free : n + 1) + int'($urandom_range(0, 4));
            for (int b = 0; b < FRAME; b++) fft_plan[b0 + b] = b;
            next_free = b0 + FRAME;
        end

        if (in_drain(n)) begin
            if (m_infl == 0) drain_exit = n;
`ifdef FFT_SEQ_WDOG_EN
            else if (m_wd == 8 * FRAME - 1 && !fe) begin
                fire = 1'b1;
                drain_exit = n;
            end
            m_wd = fe ? 0 : m_wd + 1;
        end else begin
            m_wd = 0;
`endif
        end

        if (start && !busy_at(n)) begin
            s_cyc      = n + 1;
            n_samp     = plan_n;
            drain_exit = -1;
        end

        m_fd = hit;
        if (hit) m_frames++;
        if (fire) m_infl = 0;
        else if (inc && hit) m_infl = m_infl;
        else if (inc) begin
            if (m_infl == 2) oset = 1'b1;
            else m_infl++;
        end else if (hit && m_infl > 0) m_infl--;
        if (oset) m_ovr = 1'b1;
        else if (clr_err) m_ovr = 1'b0;
        if (fire) m_tmo = 1'b1;
        else if (clr_err) m_tmo = 1'b0;

        @(posedge clk);
        #1;
        cyc++;
        start   = 1'b0;
        stop    = 1'b0;
        clr_err = 1'b0;
        compare();
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic apply_reset(input int ncyc);
        areset = 1'b0;
        #1;
        s_cyc = -1; n_samp = 0; drain_exit = -1;
        m_infl = 0; m_frames = 0; m_ovr = 1'b0; m_tmo = 1'b0; m_fd = 1'b0;
        next_free = 0;
        fft_plan.delete();
`ifdef FFT_SEQ_WDOG_EN
        m_wd = 0;
`endif
        compare();
        repeat (ncyc) begin
            core_if.fft_en = 1'b0;
            @(posedge clk);
            #1;
            cyc++;
            compare();
        end
        areset = 1'b1;
    endtask

    initial begin
        int s, offs;
        core_if.fft_en  = 1'b0;
        core_if.fft_cnt = '0;
        #1;
        apply_reset(3);
        stop = 1'b1;
        run(3);

        // single frame
        auto_ret = 1'b1; plan_n = FRAME; cont = 1'b0; start = 1'b1;
        step();
        cont = 1'b1;
        run(FLEN + 40);
        check("single_frames", 32'(frames_out), 32'd1);
        check("single_idle", 32'(busy), 32'd0);

        // continuous with stop inside the second frame
        offs = int'($urandom_range(45, 2 * FLEN));
        plan_n = FRAME * frames_for_stop(offs); cont = 1'b1; start = 1'b1;
        step();
        run(10);
        start = 1'b1; cont = 1'b0;
        step();
        run(offs - 11);
        stop = 1'b1;
        step();
        run(2 * FLEN + 40 - offs);
        check("stop_frames", 32'(frames_out), 32'd3);
        check("stop_idle", 32'(busy), 32'd0);

        // last bin of frame 1 lands on the frame-2 end cycle
        auto_ret = 1'b0; offs = int'($urandom_range(45, 60));
        plan_n = 2 * FRAME; cont = 1'b1; start = 1'b1;
        step();
        s = cyc;
        for (int b = 0; b < FRAME; b++) begin
            fft_plan[s + 2 * FLEN - (FRAME - 1) + b] = b;
            fft_plan[s + 2 * FLEN + 16 + b] = b;
        end
        run(10);
        start = 1'b1;
        step();
        run(offs - 11);
        stop = 1'b1;
        step();
        run(2 * FLEN + 40 - offs - 1);
        check("bnd_overrun", 32'(overrun), 32'd0);
        check("bnd_frames", 32'(frames_out), 32'd5);
        check("bnd_idle", 32'(busy), 32'd0);

        // overrun with no core output, then reset mid-capture
        plan_n = 100000; cont = 1'b1; start = 1'b1;
        step();
        run(3 * FLEN + 2);
        check("ovr_set", 32'(overrun), 32'd1);
        clr_err = 1'b1;
        step();
        check("ovr_clr", 32'(overrun), 32'd0);
        run(5);
        apply_reset(4);
        run(3 * FLEN);
        check("rst_frames", 32'(frames_out), 32'd0);

        // single frame whose output never comes back
        plan_n = FRAME; cont = 1'b0; start = 1'b1;
        step();
        run(FLEN + 80);
`ifdef FFT_SEQ_WDOG_EN
        check("wdog_timeout", 32'(timeout), 32'd1);
        check("wdog_idle", 32'(busy), 32'd0);
`else
        check("wdog_timeout", 32'(timeout), 32'd0);
        check("wdog_busy", 32'(busy), 32'd1);
`endif
        clr_err = 1'b1;
        step();
        check("wdog_clr", 32'(timeout), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL sim_time_limit: got cycle %0d expected completion", cyc);
        $fatal(1, "time limit");
    end

endmodule
